// File: rtl/apple_spawner_if.sv
// apple_spawner_if: bundles the pixel-scan, random-source, snake-body and
// apple-status signals of the apple spawner.
//   slave  : spawner side (consumes x/y/rand/body, drives apple status)
//   master : environment side (random generator, body register, renderer)
interface apple_spawner_if #(
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned MAX_LEN    = 50,
  parameter int unsigned NUM_APPLES = 2,
  parameter int unsigned LEN_W      = 6
);
  logic [COORD_W-1:0]              x;
  logic [COORD_W-1:0]              y;
  logic [COORD_W-1:0]              randX;
  logic [COORD_W-1:0]              randY;
  logic                            goodColl;
  logic [MAX_LEN*2*COORD_W-1:0]    body;
  logic [LEN_W-1:0]                snake_len;
  logic                            apple;
  logic [NUM_APPLES-1:0]           apple_valid;
  logic [NUM_APPLES*2*COORD_W-1:0] apple_pos;
  logic                            eat_pulse;
  logic                            busy;

  modport slave (
    input  x, y, randX, randY, goodColl, body, snake_len,
    output apple, apple_valid, apple_pos, eat_pulse, busy
  );

  modport master (
    output x, y, randX, randY, goodColl, body, snake_len,
    input  apple, apple_valid, apple_pos, eat_pulse, busy
  );
endinterface

// File: rtl/apple_spawner.sv
// apple_spawner: keeps NUM_APPLES apples on the grid, flags the scanned pixel
// when it shows an apple, detects which apple the head ate and respawns eaten
// apples from the random source, rejecting candidates that are out of range,
// on a live body segment or on another valid apple.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   s_reset - synchronous active-high game-restart reset (same effect)
//   bus     - apple_spawner_if.slave (pixel, random, body, apple status)
module apple_spawner #(
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned MAX_LEN    = 50,
  parameter int unsigned NUM_APPLES = 2,
  parameter int unsigned GRID_MAX_X = 15,
  parameter int unsigned GRID_MAX_Y = 15,
  parameter int unsigned LEN_W      = 6
) (
  input logic           clk,
  input logic           reset,
  input logic           s_reset,
  apple_spawner_if.slave bus
);

  localparam int unsigned PosW = 2 * COORD_W;
  localparam int unsigned IdxW = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

  typedef enum logic [1:0] {StIdle, StPick, StScan, StPlace} state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            target_q, target_d;
  logic [PosW-1:0]            cand_q, cand_d;
  logic [LEN_W-1:0]           idx_q, idx_d;
  logic [NUM_APPLES-1:0]      valid_q, valid_d;
  logic [NUM_APPLES*PosW-1:0] pos_q, pos_d;
  logic                       eat_q;

  // Lowest index whose valid bit is clear (0 when none is clear).
  function automatic logic [IdxW-1:0] first_free(input logic [NUM_APPLES-1:0] v);
    first_free = '0;
    for (int k = NUM_APPLES - 1; k >= 0; k--) begin
      if (!v[k]) first_free = IdxW'(k);
    end
  endfunction

  // Eat detection on pre-edge valid bits; lowest matching apple wins.
  logic                  eat_hit;
  logic [IdxW-1:0]       eat_idx;
  logic [NUM_APPLES-1:0] valid_eaten;

  always_comb begin
    eat_hit = 1'b0;
    eat_idx = '0;
    for (int k = NUM_APPLES - 1; k >= 0; k--) begin
      if (bus.goodColl && valid_q[k] &&
          pos_q[k*PosW +: PosW] == bus.body[PosW-1:0]) begin
        eat_hit = 1'b1;
        eat_idx = IdxW'(k);
      end
    end
    valid_eaten = valid_q;
    if (eat_hit) valid_eaten[eat_idx] = 1'b0;
  end

  // Candidate checks done in PICK.
  logic [PosW-1:0] cand_in;
  logic            in_range;
  logic            clash;

  assign cand_in  = {bus.randX, bus.randY};
  assign in_range = (32'(bus.randX) <= GRID_MAX_X) && (32'(bus.randY) <= GRID_MAX_Y);

  always_comb begin
    clash = 1'b0;
    for (int k = 0; k < NUM_APPLES; k++) begin
      if (IdxW'(k) != target_q && valid_q[k] && pos_q[k*PosW +: PosW] == cand_in) begin
        clash = 1'b1;
      end
    end
  end

  // Body segment under scan, read live from the body bus.
  logic [PosW-1:0] seg;
  logic            last_seg;

  always_comb begin
    seg = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_q == LEN_W'(i)) seg = bus.body[i*PosW +: PosW];
    end
  end

  // Widened so a snake_len that shrinks mid-scan still terminates the scan.
  assign last_seg = ({1'b0, idx_q} + (LEN_W + 1)'(1)) >= {1'b0, bus.snake_len};

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cand_d   = cand_q;
    idx_d    = idx_q;
    valid_d  = valid_eaten;
    pos_d    = pos_q;
    unique case (state_q)
      StIdle: begin
        if (!(&valid_eaten)) begin
          target_d = first_free(valid_eaten);
          state_d  = StPick;
        end
      end
      StPick: begin
        cand_d = cand_in;
        idx_d  = '0;
        if (in_range && !clash) begin
          state_d = (bus.snake_len == '0) ? StPlace : StScan;
        end
      end
      StScan: begin
        if (seg == cand_q) begin
          state_d = StPick;
        end else if (last_seg) begin
          state_d = StPlace;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      StPlace: begin
        // Guard: never overwrite an apple that is already valid.
        if (valid_q[target_q]) begin
          state_d = StIdle;
        end else begin
          valid_d[target_q]               = 1'b1;
          pos_d[target_q*PosW +: PosW] = cand_q;
          if (!(&valid_d)) begin
            target_d = first_free(valid_d);
            state_d  = StPick;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || s_reset) begin
      state_q  <= StPick;
      target_q <= '0;
      cand_q   <= '0;
      idx_q    <= '0;
      valid_q  <= '0;
      pos_q    <= '0;
      eat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cand_q   <= cand_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      pos_q    <= pos_d;
      eat_q    <= eat_hit;
    end
  end

  always_comb begin
    bus.apple = 1'b0;
    for (int k = 0; k < NUM_APPLES; k++) begin
      if (valid_q[k] && pos_q[k*PosW +: PosW] == {bus.x, bus.y}) bus.apple = 1'b1;
    end
  end

  assign bus.apple_valid = valid_q;
  assign bus.apple_pos   = pos_q;
  assign bus.eat_pulse   = eat_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner. Instance a uses the default 16x16 grid;
// instance b uses GRID_MAX_X=11 for the range-rejection case.
module tb_apple_spawner;

  logic tb_clk = 1'b0;
  logic reset_a, s_reset_a, reset_b, s_reset_b;
  int   errors = 0;
  int   checks = 0;

  always #5 tb_clk = ~tb_clk;

  apple_spawner_if #(.COORD_W(4), .MAX_LEN(50), .NUM_APPLES(2), .LEN_W(6)) bus_a ();
  apple_spawner_if #(.COORD_W(4), .MAX_LEN(50), .NUM_APPLES(2), .LEN_W(6)) bus_b ();

  apple_spawner #(
    .COORD_W(4), .MAX_LEN(50), .NUM_APPLES(2), .GRID_MAX_X(15), .GRID_MAX_Y(15), .LEN_W(6)
  ) dut_a (
    .clk(tb_clk), .reset(reset_a), .s_reset(s_reset_a), .bus(bus_a.slave)
  );

  apple_spawner #(
    .COORD_W(4), .MAX_LEN(50), .NUM_APPLES(2), .GRID_MAX_X(11), .GRID_MAX_Y(15), .LEN_W(6)
  ) dut_b (
    .clk(tb_clk), .reset(reset_b), .s_reset(s_reset_b), .bus(bus_b.slave)
  );

  task automatic step(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic seg_a(input int i, input logic [3:0] xx, input logic [3:0] yy);
    bus_a.body[i*8 +: 8] = {xx, yy};
  endtask

  initial begin
    reset_a = 1'b1; s_reset_a = 1'b0; reset_b = 1'b1; s_reset_b = 1'b0;
    bus_a.x = 4'd0; bus_a.y = 4'd0; bus_a.randX = 4'd15; bus_a.randY = 4'd15;
    bus_a.goodColl = 1'b0; bus_a.body = '0; bus_a.snake_len = 6'd0;
    bus_b.x = 4'd0; bus_b.y = 4'd0; bus_b.randX = 4'd2; bus_b.randY = 4'd2;
    bus_b.goodColl = 1'b0; bus_b.body = '0; bus_b.snake_len = 6'd0;

    // Power-on reset
    step(1);
    chk("rst_valid_c1", 64'(bus_a.apple_valid), 64'h0);
    chk("rst_apple_c1", 64'(bus_a.apple), 64'h0);
    step(1);
    chk("rst_valid_c2", 64'(bus_a.apple_valid), 64'h0);
    chk("rst_eat", 64'(bus_a.eat_pulse), 64'h0);
    reset_a = 1'b0;
    step(1);
    chk("por_valid_e1", 64'(bus_a.apple_valid), 64'h0);
    step(1);
    chk("por_valid_e2", 64'(bus_a.apple_valid), 64'h1);
    chk("por_pos0", 64'(bus_a.apple_pos[7:0]), 64'hff);
    chk("por_apple_00", 64'(bus_a.apple), 64'h0);
    bus_a.randX = 4'd3; bus_a.randY = 4'd4;
    step(2);
    chk("por_valid_e4", 64'(bus_a.apple_valid), 64'h3);
    chk("por_pos1", 64'(bus_a.apple_pos[15:8]), 64'h34);
    chk("por_idle", 64'(bus_a.busy), 64'h0);
    bus_a.x = 4'd15; bus_a.y = 4'd15; #1;
    chk("apple_ff", 64'(bus_a.apple), 64'h1);

    // Move apple0 to {5,8}: eat at {15,15}, snake_len=1 (latency E+3)
    seg_a(0, 4'd15, 4'd15); bus_a.snake_len = 6'd1;
    bus_a.randX = 4'd5; bus_a.randY = 4'd8; bus_a.goodColl = 1'b1;
    step(1);
    bus_a.goodColl = 1'b0;
    chk("mv_eat_pulse", 64'(bus_a.eat_pulse), 64'h1);
    chk("mv_valid_e0", 64'(bus_a.apple_valid), 64'h2);
    step(1);
    chk("mv_eat_once", 64'(bus_a.eat_pulse), 64'h0);
    step(2);
    chk("mv_valid_e3", 64'(bus_a.apple_valid), 64'h3);
    chk("mv_pos0", 64'(bus_a.apple_pos[7:0]), 64'h58);

    // Eat and respawn, snake_len=4, expect valid after E+6
    seg_a(0, 4'd5, 4'd8); seg_a(1, 4'd4, 4'd7); seg_a(2, 4'd4, 4'd6); seg_a(3, 4'd4, 4'd5);
    bus_a.snake_len = 6'd4; bus_a.randX = 4'd2; bus_a.randY = 4'd3; bus_a.goodColl = 1'b1;
    step(1);
    bus_a.goodColl = 1'b0;
    chk("eat_pulse", 64'(bus_a.eat_pulse), 64'h1);
    chk("eat_valid", 64'(bus_a.apple_valid), 64'h2);
    step(5);
    chk("eat_valid_e5", 64'(bus_a.apple_valid), 64'h2);
    step(1);
    chk("eat_valid_e6", 64'(bus_a.apple_valid), 64'h3);
    chk("eat_pos0", 64'(bus_a.apple_pos[7:0]), 64'h23);
    bus_a.x = 4'd2; bus_a.y = 4'd3; #1;
    chk("apple_23", 64'(bus_a.apple), 64'h1);
    bus_a.x = 4'd5; bus_a.y = 4'd8; #1;
    chk("apple_58", 64'(bus_a.apple), 64'h0);

    // Body rejection: {4,6} hits body[2] in SCAN, then {9,9}
    seg_a(0, 4'd2, 4'd3); bus_a.goodColl = 1'b1;
    step(1);
    bus_a.goodColl = 1'b0;
    bus_a.randX = 4'd4; bus_a.randY = 4'd6;
    step(1);
    bus_a.randX = 4'd9; bus_a.randY = 4'd9;
    step(3);
    chk("body_busy_e4", 64'(bus_a.busy), 64'h1);
    chk("body_valid_e4", 64'(bus_a.apple_valid), 64'h2);
    step(5);
    chk("body_valid_e9", 64'(bus_a.apple_valid), 64'h2);
    step(1);
    chk("body_valid_e10", 64'(bus_a.apple_valid), 64'h3);
    chk("body_pos0", 64'(bus_a.apple_pos[7:0]), 64'h99);

    // False collision
    seg_a(0, 4'd0, 4'd0); bus_a.goodColl = 1'b1;
    step(1);
    bus_a.goodColl = 1'b0;
    chk("false_eat", 64'(bus_a.eat_pulse), 64'h0);
    chk("false_valid", 64'(bus_a.apple_valid), 64'h3);
    chk("false_busy", 64'(bus_a.busy), 64'h0);

    // Soft reset mid-scan, snake_len=10
    seg_a(0, 4'd9, 4'd9);
    for (int i = 1; i < 10; i++) seg_a(i, 4'd0, 4'(i));
    bus_a.snake_len = 6'd10; bus_a.randX = 4'd7; bus_a.randY = 4'd7; bus_a.goodColl = 1'b1;
    step(1);
    bus_a.goodColl = 1'b0;
    step(3);
    chk("sr_busy_scan", 64'(bus_a.busy), 64'h1);
    s_reset_a = 1'b1;
    step(1);
    s_reset_a = 1'b0;
    bus_a.randX = 4'd1; bus_a.randY = 4'd2;
    chk("sr_valid", 64'(bus_a.apple_valid), 64'h0);
    chk("sr_pos", 64'(bus_a.apple_pos), 64'h0);
    chk("sr_busy_pick", 64'(bus_a.busy), 64'h1);
    step(11);
    chk("sr_valid_e11", 64'(bus_a.apple_valid), 64'h0);
    step(1);
    chk("sr_valid_e12", 64'(bus_a.apple_valid), 64'h1);
    chk("sr_pos0", 64'(bus_a.apple_pos[7:0]), 64'h12);

    // Range and apple-overlap rejection on instance b (GRID_MAX_X=11)
    reset_b = 1'b0;
    step(2);
    chk("b_valid_a0", 64'(bus_b.apple_valid), 64'h1);
    bus_b.randX = 4'd3; bus_b.randY = 4'd3;
    step(2);
    chk("b_valid_both", 64'(bus_b.apple_valid), 64'h3);
    bus_b.body[7:0] = 8'h22; bus_b.goodColl = 1'b1;
    step(1);
    bus_b.goodColl = 1'b0;
    chk("b_eat_pulse", 64'(bus_b.eat_pulse), 64'h1);
    bus_b.randX = 4'd12; bus_b.randY = 4'd0;
    step(1);
    bus_b.randX = 4'd3; bus_b.randY = 4'd3;
    step(1);
    chk("b_valid_e2", 64'(bus_b.apple_valid), 64'h2);
    chk("b_busy_e2", 64'(bus_b.busy), 64'h1);
    bus_b.randX = 4'd1; bus_b.randY = 4'd1;
    step(1);
    chk("b_valid_e3", 64'(bus_b.apple_valid), 64'h2);
    step(1);
    chk("b_valid_e4", 64'(bus_b.apple_valid), 64'h3);
    chk("b_pos", 64'(bus_b.apple_pos), 64'h3311);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apple_spawner.md
Name: apple_spawner

Overview:
- Parametrised multi-apple generator for the snake game.
- Holds NUM_APPLES apple positions on a grid, reports per pixel whether the scanned (x,y) shows an apple, and detects which apple the head ate on goodColl.
- Respawns eaten apples from the random source. A candidate is rejected until it is in range and clear of every live body segment and every other valid apple.
- Sits between the random generator, the snake body register and the pixel renderer.

Parameters:
- COORD_W, 4, bits per coordinate; body entry is {x, y}, 2*COORD_W bits.
- MAX_LEN, 50, body array depth.
- NUM_APPLES, 2, number of simultaneous apples (1..8).
- GRID_MAX_X, 15, largest legal x.
- GRID_MAX_Y, 15, largest legal y.
- LEN_W, 6, width of snake_len; must cover MAX_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_reset  in  1  soft (game-restart) reset; synchronous, active-high, same effect as reset.
- x  in  COORD_W  scanned pixel x.
- y  in  COORD_W  scanned pixel y.
- randX  in  COORD_W  random candidate x; new value each cycle.
- randY  in  COORD_W  random candidate y.
- goodColl  in  1  head-collision strobe, sampled each edge.
- body  in  MAX_LEN*2*COORD_W  segment i = {x, y} at bits [i*2*COORD_W +: 2*COORD_W]; body[0] is the head.
- snake_len  in  LEN_W  number of live segments; entries at index >= snake_len are ignored.
- apple  out  1  combinational: 1 when (x,y) equals any valid apple.
- apple_valid  out  NUM_APPLES  per-apple valid.
- apple_pos  out  NUM_APPLES*2*COORD_W  {x, y} of each apple.
- eat_pulse  out  1  one-cycle strobe: an apple was eaten.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset or s_reset:
  - apple_valid=0, apple_pos=0, eat_pulse=0, state=PICK, target=0.
  - Respawn of every apple starts on the next cycle; apple=0 until the first PLACE.
- Eat handling, independent of FSM state:
  - On an edge with goodColl=1, find the lowest k where apple_valid[k]=1 and apple_pos[k]==body[0].
  - If k exists: apple_valid[k]<=0 and eat_pulse<=1 for exactly one cycle.
  - If no k exists: goodColl is ignored and eat_pulse stays 0.
- FSM states:
  - IDLE: if any apple_valid bit is 0, set target = lowest invalid index and go to PICK.
  - PICK: latch cand={randX, randY} and set idx=0.
    - Reject (stay in PICK; next cycle samples a new rand) if randX>GRID_MAX_X, randY>GRID_MAX_Y, or cand equals any valid apple other than target.
    - Otherwise go to SCAN; if snake_len==0, go straight to PLACE.
  - SCAN: compare cand to body[idx], one segment per cycle.
    - Match: go to PICK.
    - No match and idx==snake_len-1: go to PLACE.
    - Otherwise idx++.
  - PLACE: apple_pos[target]<=cand and apple_valid[target]<=1.
    - Then go to PICK with the next-lowest invalid index if one exists, else IDLE.
- Latency:
  - goodColl at edge E, with an immediate accept, gives apple_valid high after edge E+2+snake_len.
  - Example: snake_len=4 → E+6.
- Body changes during SCAN:
  - The scan reads live body values.
  - Segments already passed are not rechecked.
  - Accepted behaviour; no re-scan.
- Target safety:
  - If the target apple is valid again when PLACE is reached, the write is suppressed and the FSM goes to IDLE.
  - This cannot happen from eat logic, because an eat only clears valid bits; the rule exists as a guard.
- Simultaneous eat and PLACE on the same apple: PLACE wins and the eat is ignored. The eat compare uses the pre-edge valid bits, so that apple was invalid when sampled.
- Reset or s_reset mid-SCAN aborts the scan immediately; no PLACE occurs.
- No retry limit: a full grid leaves the FSM looping in PICK/SCAN with busy=1.

Test Plan:
- Power-on reset:
  - Stimulus: reset=1 for 2 cycles, randX=15, randY=15, snake_len=0, x=y=0.
  - Required: apple_valid=0 and apple=0 during reset.
  - After release: apple_valid[0] high after 2 edges and apple_pos[0]={15,15}; apple_valid[1] high 2 edges later.
- Eat and respawn:
  - Stimulus: apple0 at {5,8}, body[0]={5,8}, snake_len=4, pulse goodColl for 1 cycle; body[1..3]={4,7},{4,6},{4,5}; randX=2, randY=3.
  - Required: eat_pulse=1 for one cycle; apple_valid[0]=0.
  - Then after E+6: apple_valid[0]=1, apple_pos[0]={2,3}.
  - With x=2, y=3: apple=1. With x=5, y=8: apple=0.
- Body rejection:
  - Stimulus: during respawn, rand={4,6} (equals body[2]) for one PICK, then {9,9}.
  - Required: candidate {4,6} is rejected in SCAN; final apple_pos={9,9}.
- Range and apple overlap rejection:
  - Stimulus: rand x=12 with GRID_MAX_X=11, then rand equal to apple1's position, then {1,1}.
  - Required: both early candidates are rejected in PICK; apple0 lands on {1,1}.
- False collision:
  - Stimulus: goodColl=1 with body[0] matching no valid apple.
  - Required: eat_pulse=0, apple_valid unchanged, busy=0.
- Soft reset mid-scan:
  - Stimulus: assert s_reset while in SCAN with snake_len=10.
  - Required: next cycle apple_valid=0, state=PICK, target=0; the aborted candidate is never placed.
